// File: rtl/id_ex_reg.sv
// ID/EX pipeline register.
// Captures decoded operands, the extended immediate and control signals from ID.
// Presents them to the EX stage one cycle later.
// Stall holds the current contents. Flush, or an invalid ID slot, loads a bubble.
module id_ex_reg #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [XLEN-1:0] id_pc4,
  input  logic [XLEN-1:0] id_rs_data,
  input  logic [XLEN-1:0] id_rt_data,
  input  logic [15:0]     id_imm,
  input  logic [4:0]      id_rs,
  input  logic [4:0]      id_rt,
  input  logic [4:0]      id_rd,
  input  logic [4:0]      id_shamt,
  input  logic [5:0]      id_funct,
  input  logic [2:0]      id_aluOp,
  input  logic [7:0]      id_ctrl,
  output logic            ex_valid,
  output logic [XLEN-1:0] ex_pc4,
  output logic [XLEN-1:0] ex_rs_data,
  output logic [XLEN-1:0] ex_rt_data,
  output logic [XLEN-1:0] ex_imm_ext,
  output logic [4:0]      ex_rs,
  output logic [4:0]      ex_rt,
  output logic [4:0]      ex_rd,
  output logic [4:0]      ex_shamt,
  output logic [5:0]      ex_funct,
  output logic [2:0]      ex_aluOp,
  output logic [6:0]      ex_ctrl,
  output logic [4:0]      ex_wreg,
  output logic [4:0]      ex_load_rd
);

  // Control bit positions within ex_ctrl / id_ctrl.
  localparam int C_REG_WRITE = 0;
  localparam int C_MEM_READ  = 2;
  localparam int C_REG_DST   = 5;
  localparam int C_EXT_ZERO  = 7;

  // One EX-stage slot. Kept as a single struct so reset, flush and hold act on every field at once.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc4;
    logic [XLEN-1:0] rs_data;
    logic [XLEN-1:0] rt_data;
    logic [XLEN-1:0] imm_ext;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      rd;
    logic [4:0]      shamt;
    logic [5:0]      funct;
    logic [2:0]      alu_op;
    logic [6:0]      ctrl;
  } slot_t;

  slot_t slot_q;
  slot_t load_d;
  slot_t bubble;
  logic  ext_bit;
  logic  take_bubble;
  logic [4:0] dest;

  // Build the bubble: a slot with no valid instruction, no control bits and pc4 parked at RESET_PC.
  always_comb begin
    bubble     = '0;
    bubble.pc4 = RESET_PC;
  end

  // Build the slot that a normal load captures, including the 16->XLEN immediate extension.
  always_comb begin
    // NOTE: every field gets a default first, so no path can leave a variable unassigned and infer a latch.
    load_d         = '0;
    ext_bit        = id_ctrl[C_EXT_ZERO] ? 1'b0 : id_imm[15];
    load_d.valid   = 1'b1;
    load_d.pc4     = id_pc4;
    load_d.rs_data = id_rs_data;
    load_d.rt_data = id_rt_data;
    load_d.imm_ext = {{(XLEN-16){ext_bit}}, id_imm};
    load_d.rs      = id_rs;
    load_d.rt      = id_rt;
    load_d.rd      = id_rd;
    load_d.shamt   = id_shamt;
    load_d.funct   = id_funct;
    load_d.alu_op  = id_aluOp;
    load_d.ctrl    = id_ctrl[6:0];
  end

  // Flush wins over stall. An empty ID slot turns a load into a bubble, so ex_ctrl is never set while ex_valid is low.
  assign take_bubble = flush | (~stall & ~id_valid);

  // Slot register with priority rst > flush > stall > load.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst || take_bubble) begin
      slot_q <= bubble;
    end else if (!stall) begin
      slot_q <= load_d;
    end
  end

  assign ex_valid   = slot_q.valid;
  assign ex_pc4     = slot_q.pc4;
  assign ex_rs_data = slot_q.rs_data;
  assign ex_rt_data = slot_q.rt_data;
  assign ex_imm_ext = slot_q.imm_ext;
  assign ex_rs      = slot_q.rs;
  assign ex_rt      = slot_q.rt;
  assign ex_rd      = slot_q.rd;
  assign ex_shamt   = slot_q.shamt;
  assign ex_funct   = slot_q.funct;
  assign ex_aluOp   = slot_q.alu_op;
  assign ex_ctrl    = slot_q.ctrl;

  // Destination and load-target indices, derived from registered fields only.
  // Writes to $zero, and instructions that do not write, report destination 0.
  always_comb begin
    dest       = slot_q.ctrl[C_REG_DST] ? slot_q.rd : slot_q.rt;
    ex_wreg    = '0;
    ex_load_rd = '0;
    if (slot_q.ctrl[C_REG_WRITE] && (dest != 5'd0)) begin
      ex_wreg = dest;
    end
    if (slot_q.ctrl[C_MEM_READ] && slot_q.valid) begin
      ex_load_rd = slot_q.rt;
    end
  end

endmodule
